// File: rtl/magnitude_max_tracker_pkg.sv
// Shared types for the streaming arg-max tracker: FSM state encoding.
// Result records are sized by the tracker's own parameters, so they are declared there.
package magnitude_max_tracker_pkg;

   typedef enum logic [1:0] {
      ST_FIRST = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/magnitude_comparator_tree.sv
// Unsigned magnitude comparator: o_a is high when i_a > i_b.
// SPLIT sets the chunk radix of the MSB-first decision; IMPLEMENTATION != 0 selects a flat compare.
module magnitude_comparator_tree #(
   parameter int WIDTH          = 32,
   parameter int SPLIT          = 2,
   parameter int IMPLEMENTATION = 0
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_a
);

   localparam int CW = (WIDTH + SPLIT - 1) / SPLIT;
   localparam int PW = CW * SPLIT;

   generate
      if (IMPLEMENTATION == 0) begin : g_chunked
         logic [PW-1:0] a_pad_s;
         logic [PW-1:0] b_pad_s;
         logic          gt_s;
         logic          done_s;

         assign a_pad_s = PW'(i_a);
         assign b_pad_s = PW'(i_b);

         // The most significant differing chunk decides the comparison
         always_comb begin
            gt_s   = 1'b0;
            done_s = 1'b0;
            for (int c = SPLIT - 1; c >= 0; c--) begin
               if (!done_s && (a_pad_s[c*CW +: CW] != b_pad_s[c*CW +: CW])) begin
                  gt_s   = (a_pad_s[c*CW +: CW] > b_pad_s[c*CW +: CW]);
                  done_s = 1'b1;
               end else begin
                  done_s = done_s;
               end
            end
         end

         assign o_a = gt_s;
      end else begin : g_direct
         assign o_a = (i_a > i_b);
      end
   endgenerate

endmodule

// File: rtl/magnitude_max_tracker.sv
// Streaming arg-max over last-delimited packets; result is presented one cycle after the last beat.
// Define MAGNITUDE_MAX_TRACKER_MIN_EN to also track the packet minimum and its index.
module magnitude_max_tracker
   import magnitude_max_tracker_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int SPLIT          = 2,
   parameter int IMPLEMENTATION = 0,
   parameter int IDX_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_vld,
   output logic                 o_rdy,
   input  logic [WIDTH-1:0]     i_dat,
   input  logic                 i_lst,
   output logic                 o_vld,
   input  logic                 i_rdy,
   output logic [WIDTH-1:0]     o_max,
   output logic [IDX_WIDTH-1:0] o_idx,
   output logic [IDX_WIDTH-1:0] o_len,
   output logic                 o_ovf,
   output logic [WIDTH-1:0]     o_min,
   output logic [IDX_WIDTH-1:0] o_min_idx
);

   typedef struct packed {
      logic [WIDTH-1:0]     max;
      logic [IDX_WIDTH-1:0] idx;
      logic [IDX_WIDTH-1:0] len;
      logic                 ovf;
   } result_t;

   localparam logic [IDX_WIDTH-1:0] CNT_MAX = {IDX_WIDTH{1'b1}};

   state_t  state_r;
   result_t acc_r;
   result_t res_r;
   result_t step_s;
   logic    vld_r;
   logic    gt_s;
   logic    cnt_sat_s;
   logic    in_xfer_s;
   logic    out_xfer_s;

   assign o_rdy      = (state_r != ST_HOLD) || i_rdy;
   assign in_xfer_s  = i_vld && o_rdy;
   assign out_xfer_s = vld_r && i_rdy;
   assign cnt_sat_s  = (acc_r.len == CNT_MAX);

   magnitude_comparator_tree #(
      .WIDTH          (WIDTH),
      .SPLIT          (SPLIT),
      .IMPLEMENTATION (IMPLEMENTATION)
   ) u_max_cmp (
      .i_a (i_dat),
      .i_b (acc_r.max),
      .o_a (gt_s)
   );

   // Running state after accepting the current beat; outside ACCUM a beat starts a new packet
   always_comb begin
      step_s = acc_r;
      if (state_r == ST_ACCUM) begin
         step_s.max = gt_s ? i_dat : acc_r.max;
         step_s.idx = gt_s ? acc_r.len : acc_r.idx;
         step_s.len = cnt_sat_s ? acc_r.len : acc_r.len + IDX_WIDTH'(1'b1);
         step_s.ovf = acc_r.ovf | cnt_sat_s;
      end else begin
         step_s.max = i_dat;
         step_s.idx = {IDX_WIDTH{1'b0}};
         step_s.len = IDX_WIDTH'(1'b1);
         step_s.ovf = 1'b0;
      end
   end

`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
   logic [WIDTH-1:0]     acc_min_r;
   logic [IDX_WIDTH-1:0] acc_min_idx_r;
   logic [WIDTH-1:0]     res_min_r;
   logic [IDX_WIDTH-1:0] res_min_idx_r;
   logic [WIDTH-1:0]     step_min_s;
   logic [IDX_WIDTH-1:0] step_min_idx_s;
   logic                 lt_s;

   // Operands swapped so o_a flags a new strict minimum
   magnitude_comparator_tree #(
      .WIDTH          (WIDTH),
      .SPLIT          (SPLIT),
      .IMPLEMENTATION (IMPLEMENTATION)
   ) u_min_cmp (
      .i_a (acc_min_r),
      .i_b (i_dat),
      .o_a (lt_s)
   );

   // Minimum tracking mirrors the maximum path
   always_comb begin
      step_min_s     = i_dat;
      step_min_idx_s = {IDX_WIDTH{1'b0}};
      if (state_r == ST_ACCUM) begin
         step_min_s     = lt_s ? i_dat : acc_min_r;
         step_min_idx_s = lt_s ? acc_r.len : acc_min_idx_r;
      end else begin
         step_min_s     = i_dat;
         step_min_idx_s = {IDX_WIDTH{1'b0}};
      end
   end

   // Minimum accumulator and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_min_r     <= {WIDTH{1'b0}};
         acc_min_idx_r <= {IDX_WIDTH{1'b0}};
         res_min_r     <= {WIDTH{1'b0}};
         res_min_idx_r <= {IDX_WIDTH{1'b0}};
      end else if (in_xfer_s) begin
         acc_min_r     <= step_min_s;
         acc_min_idx_r <= step_min_idx_s;
         if (i_lst) begin
            res_min_r     <= step_min_s;
            res_min_idx_r <= step_min_idx_s;
         end
      end
   end

   assign o_min     = res_min_r;
   assign o_min_idx = res_min_idx_r;
`else
   assign o_min     = {WIDTH{1'b0}};
   assign o_min_idx = {IDX_WIDTH{1'b0}};
`endif

   // Packet FSM: accumulate beats, publish on the last one, hand off in HOLD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_FIRST;
         acc_r   <= '0;
         res_r   <= '0;
         vld_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_FIRST, ST_ACCUM: begin
               if (in_xfer_s) begin
                  acc_r <= step_s;
                  if (i_lst) begin
                     res_r   <= step_s;
                     vld_r   <= 1'b1;
                     state_r <= ST_HOLD;
                  end else begin
                     state_r <= ST_ACCUM;
                  end
               end
            end
            ST_HOLD: begin
               if (out_xfer_s) begin
                  if (in_xfer_s) begin
                     acc_r <= step_s;
                     if (i_lst) begin
                        res_r   <= step_s;
                        vld_r   <= 1'b1;
                        state_r <= ST_HOLD;
                     end else begin
                        vld_r   <= 1'b0;
                        state_r <= ST_ACCUM;
                     end
                  end else begin
                     vld_r   <= 1'b0;
                     state_r <= ST_FIRST;
                  end
               end
            end
            default: begin
               vld_r   <= 1'b0;
               state_r <= ST_FIRST;
            end
         endcase
      end
   end

   assign o_vld = vld_r;
   assign o_max = res_r.max;
   assign o_idx = res_r.idx;
   assign o_len = res_r.len;
   assign o_ovf = res_r.ovf;

endmodule

// File: tb/tb_magnitude_max_tracker.sv
// Directed bench for magnitude_max_tracker: default instance plus an IDX_WIDTH=4 instance for saturation.
module tb_magnitude_max_tracker;

   logic        clk;
   logic        rst_n;

   logic        vld, lst, rdy;
   logic [31:0] dat;
   logic        o_rdy, o_vld, o_ovf;
   logic [31:0] o_max, o_min;
   logic [15:0] o_idx, o_len, o_min_idx;

   logic        vld4, lst4, rdy4;
   logic [31:0] dat4;
   logic        o_rdy4, o_vld4, o_ovf4;
   logic [31:0] o_max4, o_min4;
   logic [3:0]  o_idx4, o_len4, o_min_idx4;

   int compared;
   int mismatched;

   magnitude_max_tracker dut (
      .clk(clk), .rst_n(rst_n), .i_vld(vld), .o_rdy(o_rdy), .i_dat(dat), .i_lst(lst),
      .o_vld(o_vld), .i_rdy(rdy), .o_max(o_max), .o_idx(o_idx), .o_len(o_len),
      .o_ovf(o_ovf), .o_min(o_min), .o_min_idx(o_min_idx)
   );

   magnitude_max_tracker #(.IDX_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .i_vld(vld4), .o_rdy(o_rdy4), .i_dat(dat4), .i_lst(lst4),
      .o_vld(o_vld4), .i_rdy(rdy4), .o_max(o_max4), .o_idx(o_idx4), .o_len(o_len4),
      .o_ovf(o_ovf4), .o_min(o_min4), .o_min_idx(o_min_idx4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared = 0; mismatched = 0;
      rst_n = 1'b0;
      vld = 1'b0; lst = 1'b0; dat = 32'd0; rdy = 1'b1;
      vld4 = 1'b0; lst4 = 1'b0; dat4 = 32'd0; rdy4 = 1'b1;
      repeat (3) tick();
      chk("rst_vld", o_vld, 1'b0);
      chk("rst_max", o_max, 32'd0);
      chk("rst_idx", o_idx, 16'd0);
      chk("rst_len", o_len, 16'd0);
      chk("rst_ovf", o_ovf, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("rst_rdy", o_rdy, 1'b1);

      // packet 5,9,3,9,1: tie on 9 keeps index 1
      vld = 1'b1; lst = 1'b0;
      dat = 32'd5; tick();
      dat = 32'd9; tick();
      dat = 32'd3; tick();
      dat = 32'd9; tick();
      chk("p1_vld_before_last", o_vld, 1'b0);
      dat = 32'd1; lst = 1'b1; tick();
      vld = 1'b0; lst = 1'b0;
      chk("p1_vld", o_vld, 1'b1);
      chk("p1_max", o_max, 32'd9);
      chk("p1_idx", o_idx, 16'd1);
      chk("p1_len", o_len, 16'd5);
      chk("p1_ovf", o_ovf, 1'b0);
      tick();
      chk("p1_vld_consumed", o_vld, 1'b0);
      chk("p1_max_held", o_max, 32'd9);

      // back-to-back single-beat packets
      vld = 1'b1; lst = 1'b1; dat = 32'hFFFF_FFFF; tick();
      chk("s1_vld", o_vld, 1'b1);
      chk("s1_max", o_max, 32'hFFFF_FFFF);
      chk("s1_idx", o_idx, 16'd0);
      chk("s1_len", o_len, 16'd1);
      dat = 32'h11; tick();
      chk("s2_vld", o_vld, 1'b1);
      chk("s2_max", o_max, 32'h11);
      dat = 32'h22; tick();
      chk("s3_max", o_max, 32'h22);
      chk("s3_len", o_len, 16'd1);

      // backpressure: result 0x22 held while next first beat 7 waits
      rdy = 1'b0; vld = 1'b1; lst = 1'b0; dat = 32'd7;
      #1;
      chk("bp_rdy_low", o_rdy, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_vld_held", o_vld, 1'b1);
         chk("bp_max_held", o_max, 32'h22);
         chk("bp_rdy_held", o_rdy, 1'b0);
      end
      rdy = 1'b1;
      #1;
      chk("bp_rdy_follow", o_rdy, 1'b1);
      tick();
      chk("bp_handoff_vld", o_vld, 1'b0);
      dat = 32'd3; lst = 1'b1; tick();
      vld = 1'b0; lst = 1'b0;
      chk("bp_pkt_vld", o_vld, 1'b1);
      chk("bp_pkt_max", o_max, 32'd7);
      chk("bp_pkt_idx", o_idx, 16'd0);
      chk("bp_pkt_len", o_len, 16'd2);
      tick();

      // packet 8,2,6,2: minimum tracking (tied off in default build)
      vld = 1'b1; lst = 1'b0;
      dat = 32'd8; tick();
      dat = 32'd2; tick();
      dat = 32'd6; tick();
      dat = 32'd2; lst = 1'b1; tick();
      vld = 1'b0; lst = 1'b0;
      chk("mm_max", o_max, 32'd8);
      chk("mm_idx", o_idx, 16'd0);
      chk("mm_len", o_len, 16'd4);
`ifdef MAGNITUDE_MAX_TRACKER_MIN_EN
      chk("mm_min", o_min, 32'd2);
      chk("mm_min_idx", o_min_idx, 16'd1);
`else
      chk("mm_min_tied", o_min, 32'd0);
      chk("mm_min_idx_tied", o_min_idx, 16'd0);
`endif
      tick();

      // reset in the middle of a 6-beat packet discards it
      vld = 1'b1; lst = 1'b0;
      dat = 32'd10; tick();
      dat = 32'd20; tick();
      dat = 32'd30; tick();
      vld = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mr_vld", o_vld, 1'b0);
      chk("mr_max", o_max, 32'd0);
      chk("mr_len", o_len, 16'd0);
      tick();
      rst_n = 1'b1;
      vld = 1'b1;
      dat = 32'd2; tick();
      dat = 32'd4; lst = 1'b1; tick();
      vld = 1'b0; lst = 1'b0;
      chk("mr_pkt_vld", o_vld, 1'b1);
      chk("mr_pkt_max", o_max, 32'd4);
      chk("mr_pkt_idx", o_idx, 16'd1);
      chk("mr_pkt_len", o_len, 16'd2);

      // IDX_WIDTH=4: 20 beats, max 50 at beat 18 -> counters saturate at 15
      for (int k = 0; k < 20; k++) begin
         vld4 = 1'b1;
         dat4 = (k == 18) ? 32'd50 : 32'(k);
         lst4 = (k == 19);
         tick();
      end
      vld4 = 1'b0; lst4 = 1'b0;
      chk("sat_vld", o_vld4, 1'b1);
      chk("sat_max", o_max4, 32'd50);
      chk("sat_idx", o_idx4, 4'd15);
      chk("sat_len", o_len4, 4'd15);
      chk("sat_ovf", o_ovf4, 1'b1);
      chk("sat_min", o_min4, 32'd0);
      chk("sat_min_idx", o_min_idx4, 4'd0);

      // exactly 15 beats: full count without overflow
      for (int k = 0; k < 15; k++) begin
         vld4 = 1'b1;
         dat4 = (k == 14) ? 32'd9 : 32'd1;
         lst4 = (k == 14);
         tick();
      end
      vld4 = 1'b0; lst4 = 1'b0;
      chk("full_max", o_max4, 32'd9);
      chk("full_idx", o_idx4, 4'd14);
      chk("full_len", o_len4, 4'd15);
      chk("full_ovf", o_ovf4, 1'b0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
